// File: rtl/trap_sequencer.sv
// Trap entry/exit sequencer: pushes the resume PC to RA on trap, pops it on reti, redirects fetch.
// Entry takes 3 cycles from accept to redirect with grant held; waits indefinitely in WAIT_* while bus_gnt is low.
module trap_sequencer #(
    parameter logic [31:0] TRAMP_ADDR = 32'h0000_2000,
    parameter logic [31:0] RA_ADDR    = 32'hffff_ffff,
    parameter int          MAX_DEPTH  = 32,
    parameter int          HOLDOFF    = 2,
    parameter int          RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap,
    input  logic        reti,
    input  logic [31:0] core_pc,
    output logic        halt,
    output logic        redir_valid,
    output logic [31:0] redir_pc,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        strobe,
    output logic        rw,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    input  logic [31:0] d_rdata,
    output logic [5:0]  depth,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, WAIT_E, PUSH, ENTER, WAIT_X, POP, RDWAIT, EXIT
    } state_t;

    state_t      state;
    logic [7:0]  holdoff;
    logic [7:0]  lat_cnt;
    logic        reti_pend;
    logic [31:0] ret_reg;

    logic trap_live;
    logic want_exit;
    logic full;

    assign trap_live = trap && (holdoff == 8'd0);
    assign want_exit = reti || reti_pend;
    assign full      = (depth == 6'(MAX_DEPTH));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            halt        <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= 32'd0;
            bus_req     <= 1'b0;
            strobe      <= 1'b0;
            rw          <= 1'b0;
            d_addr      <= 32'd0;
            d_wdata     <= 32'd0;
            depth       <= 6'd0;
            err         <= 1'b0;
            holdoff     <= 8'd0;
            lat_cnt     <= 8'd0;
            reti_pend   <= 1'b0;
            ret_reg     <= 32'd0;
        end else begin
            if (holdoff != 8'd0)
                holdoff <= holdoff - 8'd1;
            if (reti)
                reti_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (trap_live && !full) begin
                        // A reti arriving now stays pending and is served after this frame is pushed.
                        ret_reg <= core_pc;
                        halt    <= 1'b1;
                        bus_req <= 1'b1;
                        state   <= WAIT_E;
                    end else begin
                        if (trap_live && full)
                            err <= 1'b1;
                        if (want_exit) begin
                            reti_pend <= 1'b0;
                            if (depth != 6'd0) begin
                                halt    <= 1'b1;
                                bus_req <= 1'b1;
                                state   <= WAIT_X;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                WAIT_E: begin
                    if (bus_gnt) begin
                        strobe  <= 1'b1;
                        rw      <= 1'b1;
                        d_addr  <= RA_ADDR;
                        d_wdata <= ret_reg;
                        state   <= PUSH;
                    end
                end
                PUSH: begin
                    strobe      <= 1'b0;
                    redir_valid <= 1'b1;
                    redir_pc    <= TRAMP_ADDR;
                    state       <= ENTER;
                end
                ENTER: begin
                    redir_valid <= 1'b0;
                    depth       <= depth + 6'd1;
                    holdoff     <= 8'(HOLDOFF);
                    bus_req     <= 1'b0;
                    halt        <= 1'b0;
                    state       <= IDLE;
                end
                WAIT_X: begin
                    if (bus_gnt) begin
                        strobe <= 1'b1;
                        rw     <= 1'b0;
                        d_addr <= RA_ADDR;
                        state  <= POP;
                    end
                end
                POP: begin
                    strobe  <= 1'b0;
                    lat_cnt <= 8'(RD_LAT - 1);
                    state   <= RDWAIT;
                end
                RDWAIT: begin
                    // Read data is valid in the cycle RD_LAT after the pop strobe.
                    if (lat_cnt == 8'd0) begin
                        ret_reg     <= d_rdata;
                        redir_valid <= 1'b1;
                        redir_pc    <= d_rdata;
                        state       <= EXIT;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                EXIT: begin
                    redir_valid <= 1'b0;
                    depth       <= depth - 6'd1;
                    bus_req     <= 1'b0;
                    halt        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: transaction-level stack model plus an emulated interrupt-block RA stack on the bus.
module tb_trap_sequencer;

    localparam logic [31:0] TRAMP = 32'h0000_2000;
    localparam logic [31:0] RA    = 32'hffff_ffff;
    localparam int          MAXD  = 32;
    localparam int          RDL   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trap = 1'b0;
    logic        reti = 1'b0;
    logic [31:0] core_pc = 32'd0;
    logic        bus_gnt = 1'b0;
    logic [31:0] d_rdata = 32'd0;
    logic        halt, redir_valid, bus_req, strobe, rw, err;
    logic [31:0] redir_pc, d_addr, d_wdata;
    logic [5:0]  depth;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic        merr = 1'b0;
    logic [31:0] mem_q[$];
    int          rd_cnt = 0;
    logic [31:0] rd_val = 32'd0;
    logic        prev_strobe = 1'b0;

    trap_sequencer #(
        .TRAMP_ADDR(TRAMP), .RA_ADDR(RA), .MAX_DEPTH(MAXD), .HOLDOFF(2), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .trap(trap), .reti(reti), .core_pc(core_pc),
        .halt(halt), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .strobe(strobe), .rw(rw),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Interrupt-block side: RA stack, read data returned RDL cycles after the pop strobe.
    always @(negedge clk) begin
        d_rdata = $urandom;
        if (!reset_n) begin
            mem_q.delete();
            rd_cnt = 0;
        end else begin
            if (rd_cnt != 0) begin
                if (rd_cnt == 1)
                    d_rdata = rd_val;
                rd_cnt--;
            end
            if (strobe) begin
                chk("strobe_gnt", 32'(bus_gnt & bus_req), 32'd1);
                chk("strobe_len", 32'(prev_strobe), 32'd0);
                if (rw) begin
                    mem_q.push_back(d_wdata);
                end else begin
                    rd_val = (mem_q.size() != 0) ? mem_q.pop_back() : 32'hdead_beef;
                    rd_cnt = RDL;
                end
            end
        end
        prev_strobe = strobe;
    end

    task automatic expect_entry(input logic [31:0] pc, input int stall, input bit keep);
        for (int k = 1; k <= stall + 4; k++) begin
            @(negedge clk);
            if (!keep) trap = 1'b0;
            reti = 1'b0;
            chk("e_halt", 32'(halt), 32'(k <= stall + 3));
            chk("e_strobe", 32'(strobe), 32'(k == stall + 2));
            chk("e_redir", 32'(redir_valid), 32'(k == stall + 3));
            if (k == stall + 2) begin
                chk("push_rw", 32'(rw), 32'd1);
                chk("push_addr", d_addr, RA);
                chk("push_data", d_wdata, pc);
            end
            if (k == stall + 3)
                chk("e_pc", redir_pc, TRAMP);
            bus_gnt = (k > stall);
        end
        exp_q.push_back(pc);
        chk("e_depth", 32'(depth), 32'(exp_q.size()));
        chk("e_req", 32'(bus_req), 32'd0);
    endtask

    task automatic expect_exit(input int stall);
        logic [31:0] top;
        top = exp_q[$];
        for (int k = 1; k <= stall + 6; k++) begin
            @(negedge clk);
            trap = 1'b0;
            reti = 1'b0;
            chk("x_halt", 32'(halt), 32'(k <= stall + 5));
            chk("x_strobe", 32'(strobe), 32'(k == stall + 2));
            chk("x_redir", 32'(redir_valid), 32'(k == stall + 5));
            if (k == stall + 2) begin
                chk("pop_rw", 32'(rw), 32'd0);
                chk("pop_addr", d_addr, RA);
            end
            if (k == stall + 5)
                chk("x_pc", redir_pc, top);
            bus_gnt = (k > stall);
        end
        void'(exp_q.pop_back());
        chk("x_depth", 32'(depth), 32'(exp_q.size()));
        chk("x_req", 32'(bus_req), 32'd0);
    endtask

    task automatic expect_reject(input string tag);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            trap = 1'b0;
            reti = 1'b0;
            chk({tag, "_halt"}, 32'(halt), 32'd0);
            chk({tag, "_strobe"}, 32'(strobe), 32'd0);
        end
        merr = 1'b1;
        chk({tag, "_err"}, 32'(err), 32'd1);
        chk({tag, "_depth"}, 32'(depth), 32'(exp_q.size()));
    endtask

    task automatic do_trap(input logic [31:0] pc, input int stall, input bit keep);
        repeat (3) @(negedge clk);
        trap    = 1'b1;
        core_pc = pc;
        bus_gnt = (stall == 0);
        if (exp_q.size() < MAXD)
            expect_entry(pc, stall, keep);
        else
            expect_reject("ovf");
        chk("err_flag", 32'(err), 32'(merr));
    endtask

    task automatic do_reti(input int stall);
        repeat (3) @(negedge clk);
        reti    = 1'b1;
        bus_gnt = (stall == 0);
        if (exp_q.size() != 0)
            expect_exit(stall);
        else
            expect_reject("udf");
        chk("err_flag", 32'(err), 32'(merr));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_halt"}, 32'(halt), 32'd0);
        chk({tag, "_redir"}, 32'(redir_valid), 32'd0);
        chk({tag, "_rpc"}, redir_pc, 32'd0);
        chk({tag, "_req"}, 32'(bus_req), 32'd0);
        chk({tag, "_strobe"}, 32'(strobe), 32'd0);
        chk({tag, "_rw"}, 32'(rw), 32'd0);
        chk({tag, "_addr"}, d_addr, 32'd0);
        chk({tag, "_wdata"}, d_wdata, 32'd0);
        chk({tag, "_depth"}, 32'(depth), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        trap    = 1'b0;
        reti    = 1'b0;
        bus_gnt = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        exp_q.delete();
        merr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Underflow straight out of reset.
        do_reti(0);
        do_reset();

        // Basic entry and return.
        do_trap(32'h0000_0100, 0, 1'b0);
        do_reti(0);
        chk("halt_after_ret", 32'(halt), 32'd0);

        // Trap held high across the holdoff window.
        do_trap(32'h0000_0200, 0, 1'b1);
        @(negedge clk);
        chk("ho_halt1", 32'(halt), 32'd0);
        chk("ho_strobe1", 32'(strobe), 32'd0);
        @(negedge clk);
        chk("ho_halt2", 32'(halt), 32'd0);
        expect_entry(32'h0000_0200, 0, 1'b0);
        chk("ho_depth", 32'(depth), 32'd2);
        do_reti(0);
        do_reti(0);

        // Simultaneous trap and reti at depth 1.
        do_trap(32'h0000_0300, 0, 1'b0);
        repeat (3) @(negedge clk);
        trap    = 1'b1;
        reti    = 1'b1;
        core_pc = 32'h0000_0400;
        bus_gnt = 1'b1;
        expect_entry(32'h0000_0400, 0, 1'b0);
        expect_exit(0);
        chk("simul_depth", 32'(depth), 32'd1);
        do_reti(0);

        // Grant stalls on both sides.
        do_trap(32'h0000_0500, 5, 1'b0);
        do_reti(3);

        // Random mix of entries and returns.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 6)
                do_trap($urandom, int'($urandom_range(0, 4)), 1'b0);
            else
                do_reti(int'($urandom_range(0, 4)));
        end

        // Fill the stack, then one trap too many.
        while (exp_q.size() < MAXD)
            do_trap($urandom, int'($urandom_range(0, 2)), 1'b0);
        do_trap(32'h0000_0700, 0, 1'b0);
        chk("ovf_depth", 32'(depth), 32'(MAXD));
        chk("ovf_err", 32'(err), 32'd1);

        // Reset landing in RDWAIT.
        repeat (3) @(negedge clk);
        reti    = 1'b1;
        bus_gnt = 1'b1;
        @(negedge clk);
        reti = 1'b0;
        @(negedge clk);
        chk("rdw_pop_strobe", 32'(strobe), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rdw");
        reset_n = 1'b1;
        exp_q.delete();
        merr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_strobe", 32'(strobe), 32'd0);
            chk("post_rst_redir", 32'(redir_valid), 32'd0);
        end

        // Recovery after reset.
        do_trap(32'h0000_0800, 1, 1'b0);
        do_reti(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
